// File: rtl/instr_enc.sv
// instr_enc: RV32I instruction encoder and program loader.
//
// Takes field-level commands (format, opcode, funct3/7, register indices,
// immediate), packs them into 32-bit RV32I words, buffers them in a small
// in-order FIFO and streams them into instruction memory at consecutive word
// addresses starting at BASE_ADDR.
//
// Optional build macro: INSTR_ENC_CHECK_EN
//   defined     : out-of-range immediates are treated as illegal commands
//   not defined : immediates are truncated to their fields; only cmd_fmt 6/7
//                 is illegal
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a load session (only honoured in IDLE)
//   cmd_*             command handshake and instruction fields
//   im_we/im_ready    instruction-memory write handshake
//   im_addr/im_wdata  write address and encoded word
//   busy, done, err   session status
//   dbg_state_o       current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high (cmd_valid/cmd_ready, im_we/im_ready). A producer holding valid
// keeps its payload stable until the transfer; im_addr/im_wdata do not change
// while im_we && !im_ready.
module instr_enc #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_last,
    input  logic [2:0]        cmd_fmt,
    input  logic [6:0]        cmd_op,
    input  logic [2:0]        cmd_fun3,
    input  logic [6:0]        cmd_fun7,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rs1,
    input  logic [4:0]        cmd_rs2,
    input  logic [31:0]       cmd_imm,
    output logic              im_we,
    input  logic              im_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic        full, empty, accept, legal, push, pop, is_shift, imm_ok;
    logic [31:0] enc_word;

    // ---------------- encoder ----------------
    // Shift-immediate ops carry funct7 in the upper immediate bits.
    assign is_shift = (cmd_op == 7'b0010011) &&
                      ((cmd_fun3 == 3'b001) || (cmd_fun3 == 3'b101));

    always_comb begin
        enc_word = '0;
        case (cmd_fmt)
            3'd0: enc_word = {cmd_fun7, cmd_rs2, cmd_rs1, cmd_fun3, cmd_rd, cmd_op};
            3'd1: enc_word = is_shift
                ? {cmd_fun7, cmd_imm[4:0], cmd_rs1, cmd_fun3, cmd_rd, cmd_op}
                : {cmd_imm[11:0], cmd_rs1, cmd_fun3, cmd_rd, cmd_op};
            3'd2: enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_fun3,
                              cmd_imm[4:0], cmd_op};
            3'd3: enc_word = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_fun3,
                              cmd_imm[4:1], cmd_imm[11], cmd_op};
            3'd4: enc_word = {cmd_imm[31:12], cmd_rd, cmd_op};
            3'd5: enc_word = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11],
                              cmd_imm[19:12], cmd_rd, cmd_op};
            default: enc_word = '0;
        endcase
    end

`ifdef INSTR_ENC_CHECK_EN
    // "Sign-fits N bits" means bits [31:N-1] are all equal.
    logic fits12, fits13, fits21;
    assign fits12 = (cmd_imm[31:11] == '0) || (cmd_imm[31:11] == '1);
    assign fits13 = (cmd_imm[31:12] == '0) || (cmd_imm[31:12] == '1);
    assign fits21 = (cmd_imm[31:20] == '0) || (cmd_imm[31:20] == '1);

    always_comb begin
        imm_ok = 1'b1;
        case (cmd_fmt)
            3'd1: imm_ok = is_shift ? (cmd_imm[31:5] == '0) : fits12;
            3'd2: imm_ok = fits12;
            3'd3: imm_ok = fits13 && !cmd_imm[0];
            3'd4: imm_ok = (cmd_imm[11:0] == '0);
            3'd5: imm_ok = fits21 && !cmd_imm[0];
            default: imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign legal = (cmd_fmt <= 3'd5) && imm_ok;

    // ---------------- handshakes ----------------
    assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty     = (cnt_q == '0);
    // No bypass: a pop in the same cycle does not reopen a full FIFO.
    assign cmd_ready = (state_q == S_LOAD) && !full;
    assign accept    = cmd_valid && cmd_ready;
    assign push      = accept && legal;
    assign im_we     = !empty;
    assign pop       = im_we && im_ready;

    assign im_wdata    = mem_q[rd_ptr_q];
    assign im_addr     = addr_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign dbg_state_o = state_q;

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = err_q;

        case (cnt_q == cnt_q)
            default: ;
        endcase

        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (pop && !push)
            cnt_d = cnt_q - 1'b1;

        if (pop)
            addr_d = addr_q + ADDR_W'(4);

        if (accept && !legal)
            err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = BASE_ADDR;
                    err_d   = 1'b0;
                end
            end
            S_LOAD:  if (accept && cmd_last) state_d = S_DRAIN;
            S_DRAIN: if (empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= BASE_ADDR;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= enc_word;
    end

endmodule
